// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with HALT FSM, load-use bubbles, illegal detection and instruction counter
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic                  resume,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            reg1,
  output logic [4:0]            reg2,
  output logic [4:0]            reg3,
  output logic [4:0]            s_r_amount,
  output logic [DATA_WIDTH-1:0] im_data,
  output logic [4:0]            alu_opcode,
  output logic [1:0]            jump_mux_signal,
  output logic                  write_back_on_register_mux_signal,
  output logic                  alu_input_mux_signal,
  output logic                  register_write_word_enable,
  output logic                  register_write_byte_enable,
  output logic                  memwrite_enable_a,
  output logic                  memwrite_enable_b,
  output logic                  memread_enable_a,
  output logic                  memread_enable_b,
  output logic                  PC_enable,
  output logic                  halted,
  output logic                  illegal,
  output logic                  stall,
  output logic [CNT_W-1:0]      instr_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [5:0] op;
  logic acc, halt_op, pend_v;
  logic [4:0] pend_r, d_reg1, d_reg2, d_reg3, d_sra, d_alu;
  logic [DATA_WIDTH-1:0] d_imm, sext;
  logic [1:0] d_jmp;
  logic d_wb, d_am, d_rw, d_rb, d_mwa, d_mwb, d_mra, d_mrb;
  assign op = instruction[31:26];
  assign sext = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
  assign halt_op = op == 6'd0 || op[5];
  assign stall = pend_v && pend_r != 5'd0 && in_valid && (d_reg1 == pend_r || d_reg2 == pend_r);
  assign in_ready = state == RUN && !stall && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign PC_enable = state == RUN;
  assign halted = state == HALT;
  always_comb begin
    d_reg1 = '0;
    d_reg2 = '0;
    d_reg3 = '0;
    d_sra = '0;
    d_alu = '0;
    d_imm = '0;
    d_jmp = '0;
    d_wb = 1'b0;
    d_am = 1'b0;
    d_rw = 1'b0;
    d_rb = 1'b0;
    d_mwa = 1'b0;
    d_mwb = 1'b0;
    d_mra = 1'b0;
    d_mrb = 1'b0;
    if (op >= 6'd1 && op <= 6'd15) begin
      d_reg3 = instruction[25:21];
      d_reg1 = instruction[20:16];
      d_reg2 = instruction[15:11];
      d_sra = instruction[10:6];
      d_alu = {1'b0, op[3:0]};
      d_rw = 1'b1;
      d_wb = 1'b1;
    end else if (op >= 6'd16 && op <= 6'd23) begin
      d_reg3 = instruction[25:21];
      d_reg1 = instruction[20:16];
      d_imm = sext;
      d_am = 1'b1;
      d_rw = 1'b1;
      d_wb = 1'b1;
      d_alu = op[2:0] == 3'd6 ? 5'd9 : op[2:0] == 3'd7 ? 5'd10 :
              op[2:0] >= 3'd2 ? {2'b0, op[2:0]} - 5'd1 : 5'd0;
    end else if (op >= 6'd24 && op <= 6'd27) begin
      d_reg1 = instruction[20:16];
      d_imm = sext;
      d_alu = 5'd1;
      d_am = 1'b1;
      if (!op[0]) begin
        d_reg3 = instruction[25:21];
        d_mra = !op[1];
        d_mrb = op[1];
        d_rw = !op[1];
        d_rb = op[1];
      end else begin
        d_reg2 = instruction[25:21];
        d_mwa = !op[1];
        d_mwb = op[1];
      end
    end else if (op == 6'd28) begin
      d_jmp = 2'd3;
    end else if (op == 6'd29) begin
      d_jmp = 2'd2;
      d_reg1 = instruction[25:21];
    end else if (op == 6'd30 || op == 6'd31) begin
      d_reg1 = instruction[25:21];
      d_reg2 = instruction[20:16];
      d_imm = sext;
      d_jmp = 2'd1;
      d_alu = op[0] ? 5'd15 : 5'd16;
    end
  end
  always_comb begin
    state_nx = state == RUN ? (acc && halt_op ? HALT : RUN) : (resume ? RUN : HALT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      reg1 <= '0;
      reg2 <= '0;
      reg3 <= '0;
      s_r_amount <= '0;
      im_data <= '0;
      alu_opcode <= '0;
      jump_mux_signal <= '0;
      write_back_on_register_mux_signal <= 1'b0;
      alu_input_mux_signal <= 1'b0;
      register_write_word_enable <= 1'b0;
      register_write_byte_enable <= 1'b0;
      memwrite_enable_a <= 1'b0;
      memwrite_enable_b <= 1'b0;
      memread_enable_a <= 1'b0;
      memread_enable_b <= 1'b0;
      illegal <= 1'b0;
      pend_v <= 1'b0;
      pend_r <= '0;
      instr_count <= '0;
    end else begin
      if (acc) begin
        out_valid <= !halt_op;
        reg1 <= d_reg1;
        reg2 <= d_reg2;
        reg3 <= d_reg3;
        s_r_amount <= d_sra;
        im_data <= d_imm;
        alu_opcode <= d_alu;
        jump_mux_signal <= d_jmp;
        write_back_on_register_mux_signal <= d_wb;
        alu_input_mux_signal <= d_am;
        register_write_word_enable <= d_rw;
        register_write_byte_enable <= d_rb;
        memwrite_enable_a <= d_mwa;
        memwrite_enable_b <= d_mwb;
        memread_enable_a <= d_mra;
        memread_enable_b <= d_mrb;
        instr_count <= instr_count + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc && op[5]) illegal <= 1'b1;
      pend_v <= out_valid && out_ready && (memread_enable_a || memread_enable_b);
      pend_r <= reg3;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  logic clk, rst_n, in_valid, in_ready, resume, out_valid, out_ready;
  logic [31:0] instruction, im_data;
  logic [4:0] reg1, reg2, reg3, s_r_amount, alu_opcode;
  logic [1:0] jump_mux_signal;
  logic wb_mux, alu_mux, rw_word, rw_byte, mw_a, mw_b, mr_a, mr_b;
  logic pc_en, halted, illegal, stall;
  logic [15:0] instr_count;
  logic c_in_ready, c_out_valid, c_wb, c_am, c_rw, c_rb, c_mwa, c_mwb, c_mra, c_mrb;
  logic c_pc, c_halted, c_illegal, c_stall;
  logic [31:0] c_im;
  logic [4:0] c_r1, c_r2, c_r3, c_sra, c_alu;
  logic [1:0] c_jmp, c_cnt;
  int total = 0;
  int bad = 0;
  localparam logic [31:0] ADD_R = 32'h0462_2000;
  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .s_r_amount(s_r_amount), .im_data(im_data),
    .alu_opcode(alu_opcode), .jump_mux_signal(jump_mux_signal),
    .write_back_on_register_mux_signal(wb_mux), .alu_input_mux_signal(alu_mux),
    .register_write_word_enable(rw_word), .register_write_byte_enable(rw_byte),
    .memwrite_enable_a(mw_a), .memwrite_enable_b(mw_b),
    .memread_enable_a(mr_a), .memread_enable_b(mr_b),
    .PC_enable(pc_en), .halted(halted), .illegal(illegal), .stall(stall),
    .instr_count(instr_count)
  );
  decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .instruction(instruction), .resume(resume), .out_valid(c_out_valid), .out_ready(out_ready),
    .reg1(c_r1), .reg2(c_r2), .reg3(c_r3), .s_r_amount(c_sra), .im_data(c_im),
    .alu_opcode(c_alu), .jump_mux_signal(c_jmp),
    .write_back_on_register_mux_signal(c_wb), .alu_input_mux_signal(c_am),
    .register_write_word_enable(c_rw), .register_write_byte_enable(c_rb),
    .memwrite_enable_a(c_mwa), .memwrite_enable_b(c_mwb),
    .memread_enable_a(c_mra), .memread_enable_b(c_mrb),
    .PC_enable(c_pc), .halted(c_halted), .illegal(c_illegal), .stall(c_stall),
    .instr_count(c_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    resume = 1'b0;
    out_ready = 1'b1;
    instruction = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    resume = 1'b0;
    out_ready = 1'b1;
    instruction = ADD_R;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL rst_pc_enable got=%0h exp=1", pc_en); end
    total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0h%0h exp=00", halted, illegal); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", instr_count); end
    total++; if (reg3 !== 5'd0 || im_data !== 32'd0) begin bad++; $display("FAIL rst_fields got=%0h/%0h exp=0/0", reg3, im_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    rst_n = 1'b1;
  endtask
  task automatic test_rtype();
    do_reset();
    instruction = ADD_R;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rt_in_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rt_out_valid got=%0h exp=1", out_valid); end
    total++; if ({reg3, reg1, reg2} !== {5'd3, 5'd2, 5'd4}) begin bad++; $display("FAIL rt_regs got=%0d,%0d,%0d exp=3,2,4", reg3, reg1, reg2); end
    total++; if (alu_opcode !== 5'd1) begin bad++; $display("FAIL rt_alu got=%0d exp=1", alu_opcode); end
    total++; if ({rw_word, wb_mux, alu_mux} !== 3'b110) begin bad++; $display("FAIL rt_ctrl got=%b exp=110", {rw_word, wb_mux, alu_mux}); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL rt_count got=%0d exp=1", instr_count); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rt_drop got=%0h exp=0", out_valid); end
  endtask
  task automatic test_itype();
    do_reset();
    instruction = {6'd16, 5'd7, 5'd1, 16'hFFFE};
    in_valid = 1'b1;
    step();
    total++; if (im_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL it_imm got=%h exp=fffffffe", im_data); end
    total++; if ({alu_mux, alu_opcode} !== {1'b1, 5'd0}) begin bad++; $display("FAIL it16_alu got=%0h/%0d exp=1/0", alu_mux, alu_opcode); end
    total++; if ({reg3, reg1} !== {5'd7, 5'd1}) begin bad++; $display("FAIL it_regs got=%0d,%0d exp=7,1", reg3, reg1); end
    instruction = {6'd22, 5'd7, 5'd1, 16'h0005};
    step();
    total++; if (alu_opcode !== 5'd9) begin bad++; $display("FAIL it22_alu got=%0d exp=9", alu_opcode); end
    total++; if (im_data !== 32'h0000_0005) begin bad++; $display("FAIL it22_imm got=%h exp=00000005", im_data); end
    instruction = {6'd25, 5'd9, 5'd1, 16'h0010};
    step();
    in_valid = 1'b0;
    total++; if ({mw_a, reg2, rw_word, alu_opcode} !== {1'b1, 5'd9, 1'b0, 5'd1}) begin bad++; $display("FAIL sw_dec got=%0h,%0d,%0h,%0d exp=1,9,0,1", mw_a, reg2, rw_word, alu_opcode); end
  endtask
  task automatic test_load_use();
    do_reset();
    instruction = {6'd24, 5'd5, 5'd1, 16'd4};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if ({mr_a, rw_word, wb_mux} !== 3'b110) begin bad++; $display("FAIL lw_ctrl got=%b exp=110", {mr_a, rw_word, wb_mux}); end
    step();
    instruction = {6'd1, 5'd6, 5'd5, 5'd2, 11'd0};
    in_valid = 1'b1;
    #1;
    total++; if ({stall, in_ready} !== 2'b10) begin bad++; $display("FAIL lu_stall got=%b exp=10", {stall, in_ready}); end
    step();
    total++; if ({stall, in_ready} !== 2'b01) begin bad++; $display("FAIL lu_release got=%b exp=01", {stall, in_ready}); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL lu_count_mid got=%0d exp=1", instr_count); end
    step();
    in_valid = 1'b0;
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL lu_count got=%0d exp=2", instr_count); end
    total++; if ({out_valid, reg1, reg3} !== {1'b1, 5'd5, 5'd6}) begin bad++; $display("FAIL lu_add got=%0h,%0d,%0d exp=1,5,6", out_valid, reg1, reg3); end
    do_reset();
    instruction = {6'd24, 5'd0, 5'd1, 16'd4};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    instruction = {6'd1, 5'd6, 5'd0, 5'd2, 11'd0};
    in_valid = 1'b1;
    #1;
    total++; if ({stall, in_ready} !== 2'b01) begin bad++; $display("FAIL lu_r0_nostall got=%b exp=01", {stall, in_ready}); end
    step();
    in_valid = 1'b0;
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL lu_r0_count got=%0d exp=2", instr_count); end
  endtask
  task automatic test_halt();
    do_reset();
    instruction = 32'h0;
    in_valid = 1'b1;
    step();
    instruction = ADD_R;
    total++; if ({halted, pc_en, out_valid} !== 3'b100) begin bad++; $display("FAIL halt_state got=%b exp=100", {halted, pc_en, out_valid}); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL halt_count got=%0d exp=1", instr_count); end
    for (int i = 0; i < 10; i++) begin
      total++; if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL halt_hold%0d got=%b exp=00", i, {in_ready, out_valid}); end
      step();
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    total++; if ({in_ready, halted, pc_en} !== 3'b101) begin bad++; $display("FAIL resume got=%b exp=101", {in_ready, halted, pc_en}); end
    step();
    in_valid = 1'b0;
    total++; if ({out_valid, instr_count} !== {1'b1, 16'd2}) begin bad++; $display("FAIL resume_accept got=%0h,%0d exp=1,2", out_valid, instr_count); end
  endtask
  task automatic test_illegal();
    do_reset();
    instruction = {6'd40, 26'd0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if ({illegal, halted, out_valid} !== 3'b110) begin bad++; $display("FAIL ill_set got=%b exp=110", {illegal, halted, out_valid}); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    total++; if ({illegal, halted} !== 2'b10) begin bad++; $display("FAIL ill_sticky got=%b exp=10", {illegal, halted}); end
    instruction = {6'd40, 26'd0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    resume = 1'b1;
    step();
    rst_n = 1'b1;
    resume = 1'b0;
    total++; if ({illegal, halted, pc_en, instr_count} !== {3'b001, 16'd0}) begin bad++; $display("FAIL ill_reset got=%b,%0d exp=001,0", {illegal, halted, pc_en}, instr_count); end
  endtask
  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    instruction = ADD_R;
    in_valid = 1'b1;
    step();
    instruction = {6'd16, 5'd7, 5'd1, 16'hFFFE};
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if ({out_valid, in_ready, reg3, reg1, instr_count} !== {2'b10, 5'd3, 5'd2, 16'd1}) begin bad++; $display("FAIL bp_hold%0d got=%b,%0d,%0d,%0d exp=10,3,2,1", i, {out_valid, in_ready}, reg3, reg1, instr_count); end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if ({reg3, im_data, instr_count} !== {5'd7, 32'hFFFF_FFFE, 16'd2}) begin bad++; $display("FAIL bp_next got=%0d,%h,%0d exp=7,fffffffe,2", reg3, im_data, instr_count); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    instruction = ADD_R;
    in_valid = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    total++; if (instr_count !== 16'd5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", instr_count); end
    total++; if (c_cnt !== 2'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", c_cnt); end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_use();
    test_halt();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction decode stage for the CPU datapath. It sits between fetch and execute, with a valid/ready handshake on both sides. It decodes one 32-bit instruction per cycle into register addresses, a sign-extended immediate, the ALU opcode and control strobes. It adds a HALT/resume state machine, load-use hazard bubbles, illegal-opcode detection and an accepted-instruction counter.

## Interface
- DATA_WIDTH, 32, width of im_data; the 16-bit immediate is sign-extended to this width (must be >= 16)
- CNT_W, 16, width of instr_count
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction present on instruction
- in_ready  out  1  stage accepts instruction this cycle
- instruction  in  32  opcode in [31:26]
- resume  in  1  leave HALT (one-cycle pulse)
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- reg1, reg2, reg3  out  5 each  source 1, source 2, destination
- s_r_amount  out  5  shift amount
- im_data  out  DATA_WIDTH  sign-extended immediate
- alu_opcode  out  5
- jump_mux_signal  out  2  0 = pc+4; 1 = pc+imm; 2 = reg1; 3 = {pc[31:28], instruction[25:0], 2'b00}
- write_back_on_register_mux_signal  out  1  1 = ALU result, 0 = memory
- alu_input_mux_signal  out  1  1 = immediate
- register_write_word_enable, register_write_byte_enable  out  1 each
- memwrite_enable_a, memwrite_enable_b, memread_enable_a, memread_enable_b  out  1 each  a = word, b = byte
- PC_enable  out  1  high only in RUN
- halted, illegal  out  1 each  illegal is sticky until reset
- stall  out  1  load-use bubble this cycle
- instr_count  out  CNT_W  accepted instructions

## Operation
Reset, while rst_n = 0 at a clock edge:
- Every registered output is 0; state = RUN; PC_enable = 1.
- in_ready follows the formula below.

States:
- RUN: decodes instructions.
- HALT: in_ready = 0, PC_enable = 0, halted = 1.
- RUN -> HALT on accepting opcode 0 or any opcode >= 32. Opcodes >= 32 also set illegal.
- HALT -> RUN on resume. resume in RUN is ignored.
- The accepted opcode 0 or illegal instruction is emitted as a bubble: out_valid stays 0.

Acceptance: in_ready = RUN && !stall && (!out_valid || out_ready).

Decode on accept. Fields not listed are driven to 0, never Z.
- 1–15 (R-type):
  - reg3 = [25:21], reg1 = [20:16], reg2 = [15:11], s_r_amount = [10:6].
  - alu_opcode = {1'b0, [29:26]}.
  - Word write-enable, wb mux = 1, alu mux = 0.
- 16–23 (I-type):
  - reg3 = [25:21], reg1 = [20:16], im_data = sext([15:0]).
  - alu mux = 1, word write-enable, wb mux = 1.
  - alu_opcode from op[3:0]: 2→1, 3→2, 4→3, 5→4, 6→9, 7→10, else 0.
- 24 LW / 26 LB:
  - reg3 = [25:21], reg1 = [20:16], im_data sext, alu_opcode = 1, alu mux = 1, wb mux = 0.
  - Read strobe a (LW) or b (LB); word (LW) or byte (LB) write-enable.
- 25 SW / 27 SB:
  - reg2 = [25:21] (data), reg1 = [20:16] (base), im_data sext, alu_opcode = 1, alu mux = 1.
  - Write strobe a (SW) or b (SB); no register write.
- 28: jump_mux_signal = 3.
- 29: jump_mux_signal = 2, reg1 = [25:21].
- 30, 31 (branches):
  - reg1 = [25:21], reg2 = [20:16], im_data sext, jump_mux_signal = 1.
  - alu_opcode = 16 (op 30) or 15 (op 31).

Load-use hazard:
- When a LW/LB bundle is handed off (out_valid && out_ready), its reg3 is latched as pending for exactly the next cycle.
- In that cycle, stall = 1 (in_ready = 0) if the presented instruction reads the pending register, pending reg3 != 0, and in_valid = 1.
- "Reads" means reg1 for any opcode 1–31 except 28; it also means reg2 for R-type, stores and branches.
- The pending latch clears unconditionally after that cycle, so at most one bubble is inserted per load.

instr_count increments on every in_valid && in_ready, including halts and illegals. It wraps modulo 2^CNT_W.

## Timing
- Latency: 1 cycle from acceptance to out_valid.
- Back-to-back throughput: 1 instruction per cycle while out_ready = 1.
- Output holds stable while out_valid && !out_ready.
- out_valid drops the cycle after consumption if nothing was accepted.
- HALT is entered in the cycle after the halting instruction is accepted; PC_enable is 0 from that edge.
- resume in cycle N gives in_ready = 1 in cycle N+1.
- resume and rst_n = 0 together: reset wins.
- Reset mid-stall or mid-HALT: back to RUN, all outputs 0, pending latch cleared, illegal cleared.
- Downstream back-pressure during a pending-latch cycle: in_ready is 0 anyway; the pending latch still clears.

## Test plan
- Reset, then R-type 0x0462_2000 (op 1, rd 3, rs1 2, rs2 4) -> next cycle out_valid = 1, reg3 = 3, reg1 = 2, reg2 = 4, alu_opcode = 1, word write-enable = 1.
- I-type op 16 with imm 0xFFFE -> im_data = 0xFFFF_FFFE, alu mux = 1, alu_opcode = 0. Same with op 22 -> alu_opcode = 9.
- LW rd = 5, then ADD reading reg1 = 5 held on the input -> exactly one stall cycle, the ADD is accepted the following cycle, instr_count = 2. Repeat with rd = 0 -> no stall.
- Opcode 0 -> out_valid stays 0, halted = 1, PC_enable = 0, in_ready = 0 for 10 cycles. resume pulse -> in_ready = 1 next cycle.
- Opcode 40 -> illegal = 1 and halted = 1; illegal persists after resume until rst_n low.
- Hold out_ready = 0 with a valid bundle for 5 cycles -> outputs unchanged, in_ready = 0. Set CNT_W = 2 and accept 5 instructions -> instr_count = 1.
